// File: rtl/slm_pkg.sv
// rtl/slm_pkg.sv - shared types and defaults for the SLM frame/line sequencer
package slm_pkg;

  localparam int WORD_W                  = 32;
  localparam int DEFAULT_WORDS_PER_LINE  = 40;
  localparam int DEFAULT_LINES_PER_FRAME = 1024;
  localparam int DEFAULT_RESET_HOLD      = 4;

  typedef logic [WORD_W-1:0] slm_word_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FILL       = 2'd1,
    READY      = 2'd2,
    FRAME_END  = 2'd3
  } slm_state_t;

  // Bits needed to hold values 0..max_val inclusive (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/slm_reset_stretcher.sv
// rtl/slm_reset_stretcher.sv - holds reset_all high for RESET_HOLD cycles after reset falls
module slm_reset_stretcher
  import slm_pkg::*;
#(
  parameter int RESET_HOLD = DEFAULT_RESET_HOLD
) (
  input  logic clk,
  input  logic reset,
  output logic reset_all
);

  localparam int HCW = cnt_width(RESET_HOLD);
  localparam logic [HCW-1:0] HOLD = HCW'(RESET_HOLD);
  localparam logic [HCW-1:0] ONE  = HCW'(1);

  logic [HCW-1:0] hold_cnt;

  // Load the hold count during reset, then count down; the last count drops reset_all.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= HOLD;
      reset_all <= 1'b1;
    end else if (hold_cnt > ONE) begin
      hold_cnt  <= hold_cnt - ONE;
      reset_all <= 1'b1;
    end else begin
      hold_cnt  <= '0;
      reset_all <= 1'b0;
    end
  end

endmodule

// File: rtl/slm_timing_controller.sv
// rtl/slm_timing_controller.sv - moves one line at a time from dc32 to sc32 and sequences frames
module slm_timing_controller
  import slm_pkg::*;
#(
  parameter int WORDS_PER_LINE  = DEFAULT_WORDS_PER_LINE,
  parameter int LINES_PER_FRAME = DEFAULT_LINES_PER_FRAME,
  parameter int RESET_HOLD      = DEFAULT_RESET_HOLD
) (
  input  logic              fpga_clk,
  input  logic              reset,
  output logic              reset_all,
  output logic              reset_per_frame,
  output logic              buffer_switch_done,
  input  logic              dc32_fifo_full,
  input  logic              dc32_fifo_almost_empty,
  output logic              dc32_fifo_read_enable,
  input  logic [WORD_W-1:0] dc32_fifo_data_out,
  output logic              sc32_fifo_write_enable,
  output logic              sc32_fifo_read_enable,
  output logic [WORD_W-1:0] sc32_fifo_data_in,
  output logic              line_of_data_available,
  input  logic              get_next_word,
  output logic              update,
  output logic              invert
);

  localparam int WCW = cnt_width(WORDS_PER_LINE);
  localparam int LCW = cnt_width(LINES_PER_FRAME);
  localparam logic [WCW-1:0] WORDS_FULL = WCW'(WORDS_PER_LINE);
  localparam logic [WCW-1:0] WORDS_LAST = WCW'(WORDS_PER_LINE - 1);
  localparam logic [WCW-1:0] WORD_ONE   = WCW'(1);
  localparam logic [LCW-1:0] LINES_LAST = LCW'(LINES_PER_FRAME - 1);
  localparam logic [LCW-1:0] LINE_ONE   = LCW'(1);

  slm_state_t     state;
  logic [WCW-1:0] word_cnt;   // reads issued to dc32 in FILL, reads from sc32 in READY
  logic [LCW-1:0] line_cnt;   // lines completed in the current frame

  slm_reset_stretcher #(
    .RESET_HOLD(RESET_HOLD)
  ) u_reset_stretcher (
    .clk      (fpga_clk),
    .reset    (reset),
    .reset_all(reset_all)
  );

  // dc32 data arrives one cycle after the read strobe, exactly when the sc32 write fires.
  assign sc32_fifo_data_in = dc32_fifo_data_out;

  // Read dc32 only while filling, only when it has data to spare, and never past one line.
  assign dc32_fifo_read_enable = (state == FILL) && !dc32_fifo_almost_empty &&
                                 (word_cnt != WORDS_FULL);

  // The pixel driver can only pull words while a complete line is on offer.
  assign sc32_fifo_read_enable = get_next_word && line_of_data_available;

  // Line/frame sequencer: fill a line, hand it over, repeat; close the frame with update then switch.
  always_ff @(posedge fpga_clk) begin
    if (reset || reset_all) begin
      state                  <= WAIT_FRAME;
      word_cnt               <= '0;
      line_cnt               <= '0;
      sc32_fifo_write_enable <= 1'b0;
      line_of_data_available <= 1'b0;
      update                 <= 1'b0;
      reset_per_frame        <= 1'b0;
      buffer_switch_done     <= 1'b0;
      invert                 <= 1'b0;
    end else begin
      sc32_fifo_write_enable <= dc32_fifo_read_enable;
      update                 <= 1'b0;
      reset_per_frame        <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          word_cnt           <= '0;
          line_cnt           <= '0;
          buffer_switch_done <= 1'b0;
          if (dc32_fifo_full) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (dc32_fifo_read_enable) begin
            word_cnt <= word_cnt + WORD_ONE;
          end
          // The final write is in flight once all reads are issued; the line is complete after it.
          if (sc32_fifo_write_enable && (word_cnt == WORDS_FULL)) begin
            state                  <= READY;
            word_cnt               <= '0;
            line_of_data_available <= 1'b1;
          end
        end
        READY: begin
          if (sc32_fifo_read_enable) begin
            if (word_cnt == WORDS_LAST) begin
              word_cnt               <= '0;
              line_of_data_available <= 1'b0;
              line_cnt               <= line_cnt + LINE_ONE;
              if (line_cnt == LINES_LAST) begin
                state           <= FRAME_END;
                update          <= 1'b1;
                reset_per_frame <= 1'b1;
                invert          <= ~invert;
              end else begin
                state <= FILL;
              end
            end else begin
              word_cnt <= word_cnt + WORD_ONE;
            end
          end
        end
        FRAME_END: begin
          if (!buffer_switch_done) begin
            buffer_switch_done <= 1'b1;
          end else begin
            buffer_switch_done <= 1'b0;
            line_cnt           <= '0;
            state              <= WAIT_FRAME;
          end
        end
        default: begin
          state <= WAIT_FRAME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slm_timing_controller.sv
// tb/tb_slm_timing_controller.sv - table-driven and sequence checks for slm_timing_controller
module tb_slm_timing_controller;

  localparam int WPL = 4;
  localparam int LPF = 2;
  localparam int RH  = 4;

  logic        fpga_clk;
  logic        reset;
  logic        reset_all;
  logic        reset_per_frame;
  logic        buffer_switch_done;
  logic        dc32_fifo_full;
  logic        dc32_fifo_almost_empty;
  logic        dc32_fifo_read_enable;
  logic [31:0] dc32_fifo_data_out;
  logic        sc32_fifo_write_enable;
  logic        sc32_fifo_read_enable;
  logic [31:0] sc32_fifo_data_in;
  logic        line_of_data_available;
  logic        get_next_word;
  logic        update;
  logic        invert;

  slm_timing_controller #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .RESET_HOLD     (RH)
  ) dut (
    .fpga_clk              (fpga_clk),
    .reset                 (reset),
    .reset_all             (reset_all),
    .reset_per_frame       (reset_per_frame),
    .buffer_switch_done    (buffer_switch_done),
    .dc32_fifo_full        (dc32_fifo_full),
    .dc32_fifo_almost_empty(dc32_fifo_almost_empty),
    .dc32_fifo_read_enable (dc32_fifo_read_enable),
    .dc32_fifo_data_out    (dc32_fifo_data_out),
    .sc32_fifo_write_enable(sc32_fifo_write_enable),
    .sc32_fifo_read_enable (sc32_fifo_read_enable),
    .sc32_fifo_data_in     (sc32_fifo_data_in),
    .line_of_data_available(line_of_data_available),
    .get_next_word         (get_next_word),
    .update                (update),
    .invert                (invert)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // {reset_all, dc32_rd, sc32_wr, sc32_rd, line_avail, update, reset_per_frame, buf_switch, invert}
  logic [8:0] outs;
  assign outs = {reset_all, dc32_fifo_read_enable, sc32_fifo_write_enable, sc32_fifo_read_enable,
                 line_of_data_available, update, reset_per_frame, buffer_switch_done, invert};

  typedef struct packed {
    logic       rst;
    logic       full;
    logic       ae;
    logic       gnw;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic f, input logic a, input logic g, input logic [8:0] e);
    vec_t v;
    v.rst = r; v.full = f; v.ae = a; v.gnw = g; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, then let combinational outputs settle.
  task automatic cycle(input logic r, input logic f, input logic a, input logic g, input logic [31:0] d);
    @(posedge fpga_clk);
    #1;
    reset = r; dc32_fifo_full = f; dc32_fifo_almost_empty = a; get_next_word = g;
    dc32_fifo_data_out = d;
    #1;
  endtask

  task automatic run_frame(input logic exp_inv, input string tag);
    int rd_n = 0, re_n = 0, upd_n = 0, rpf_n = 0;
    int upd_c = -1, bsd_c = -1, c = 0;
    logic inv_at_upd = 1'bx;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    while (bsd_c < 0 && c < 80) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h5A5A_0000 + 32'(c));
      if (dc32_fifo_read_enable) rd_n++;
      if (sc32_fifo_read_enable) re_n++;
      if (update) begin upd_n++; upd_c = c; inv_at_upd = invert; end
      if (reset_per_frame) rpf_n++;
      if (reset_per_frame && !update) check({tag, "_rpf_with_upd"}, 32'(update), 32'd1);
      if (buffer_switch_done) bsd_c = c;
      c++;
    end
    check({tag, "_done_in_budget"}, 32'(bsd_c >= 0), 32'd1);
    check({tag, "_dc32_reads"}, 32'(rd_n), 32'(WPL * LPF));
    check({tag, "_sc32_reads"}, 32'(re_n), 32'(WPL * LPF));
    check({tag, "_update_pulses"}, 32'(upd_n), 32'd1);
    check({tag, "_rpf_pulses"}, 32'(rpf_n), 32'd1);
    check({tag, "_bsd_after_upd"}, 32'(bsd_c), 32'(upd_c + 1));
    check({tag, "_invert_at_upd"}, 32'(inv_at_upd), 32'(exp_inv));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check({tag, "_idle_after"}, 32'(outs), {23'd0, 8'd0, exp_inv});
  endtask

  initial begin
    int lda_c;
    reset = 1'b1; dc32_fifo_full = 1'b0; dc32_fifo_almost_empty = 1'b0;
    get_next_word = 1'b0; dc32_fifo_data_out = '0;
    repeat (2) @(posedge fpga_clk);

    // reset, stretched reset with FSM held, first frame, start of second frame
    add(1, 0, 0, 0, 9'b100000000);
    add(0, 0, 0, 0, 9'b100000000);
    add(0, 1, 0, 0, 9'b100000000);
    add(0, 1, 0, 0, 9'b100000000);
    add(0, 1, 0, 0, 9'b100000000);
    add(0, 1, 0, 0, 9'b000000000);
    add(0, 0, 0, 0, 9'b010000000);
    add(0, 0, 0, 0, 9'b011000000);
    add(0, 0, 1, 0, 9'b001000000);
    add(0, 0, 1, 0, 9'b000000000);
    add(0, 0, 1, 0, 9'b000000000);
    add(0, 0, 0, 0, 9'b010000000);
    add(0, 0, 0, 0, 9'b011000000);
    add(0, 0, 0, 1, 9'b001000000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 0, 9'b000010000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 0, 9'b000010000);
    add(0, 0, 0, 0, 9'b000010000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b010000000);
    add(0, 0, 0, 0, 9'b011000000);
    add(0, 0, 0, 0, 9'b011000000);
    add(0, 0, 0, 0, 9'b011000000);
    add(0, 0, 0, 0, 9'b001000000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b000110000);
    add(0, 0, 0, 1, 9'b000001101);
    add(0, 0, 0, 0, 9'b000000011);
    add(0, 0, 0, 0, 9'b000000001);
    add(0, 0, 0, 0, 9'b000000001);
    add(0, 1, 0, 0, 9'b000000001);
    add(0, 0, 0, 0, 9'b010000001);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].full, tbl[i].ae, tbl[i].gnw, 32'hC0DE_0000 + 32'(i));
      check($sformatf("row%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
      check($sformatf("row%0d_data", i), sc32_fifo_data_in, 32'hC0DE_0000 + 32'(i));
    end

    // finish filling the first line of frame two, then read two words and reset in READY
    lda_c = 0;
    while (!line_of_data_available && lda_c < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      lda_c++;
    end
    check("mid_lda_seen", 32'(line_of_data_available), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("mid_read1", 32'(sc32_fifo_read_enable), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("mid_read2", 32'(sc32_fifo_read_enable), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < RH; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check($sformatf("rst_hold%0d", k), 32'(outs), 32'b100000000);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      check($sformatf("rst_wait_full%0d", k), 32'(outs), 32'b000000000);
    end

    // two complete frames from a clean start: invert goes 0->1 then back to 0
    run_frame(1'b1, "frame_a");
    run_frame(1'b0, "frame_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slm_timing_controller.md
Name: slm_timing_controller

Overview:
Frame/line sequencer for the SLM display path. It moves 32-bit words from the FTDI-side dual-clock FIFO (dc32, read side on fpga_clk) into the line-buffer single-clock FIFO (sc32), one line at a time. It hands each line to the pixel driver, which pulls words with get_next_word. At end of frame it issues update, toggles invert (DC balance), and pulses the per-frame reset and buffer-switch flags.

Parameters:
WORDS_PER_LINE, 40, 32-bit words per display line (>=2)
LINES_PER_FRAME, 1024, lines per frame (>=1)
RESET_HOLD, 4, cycles reset_all stays high after reset deasserts

Ports:
fpga_clk  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
reset_all  out  1  stretched global reset for downstream blocks
reset_per_frame  out  1  1-cycle pulse at frame end; flushes sc32 and per-frame state downstream
buffer_switch_done  out  1  1-cycle pulse, cycle after update
dc32_fifo_full  in  1  dc32 full; primes frame start
dc32_fifo_almost_empty  in  1  dc32 holds <=1 word; no reads while high
dc32_fifo_read_enable  out  1  dc32 read strobe; data valid next cycle
dc32_fifo_data_out  in  32  dc32 read data
sc32_fifo_write_enable  out  1  sc32 write strobe
sc32_fifo_read_enable  out  1  sc32 read strobe
sc32_fifo_data_in  out  32  sc32 write data
line_of_data_available  out  1  a full line is in sc32 and may be read
get_next_word  in  1  pixel driver requests next word
update  out  1  1-cycle SLM update pulse at frame end
invert  out  1  frame polarity; toggles once per frame

Behaviour:
- Reset (reset=1): all outputs 0 except reset_all=1. State=WAIT_FRAME. Counters=0. invert=0.
- reset_all: 1 during reset and for exactly RESET_HOLD cycles after reset falls, then 0. The FSM is held in WAIT_FRAME while reset_all=1.
- Read latency: sc32_fifo_write_enable is dc32_fifo_read_enable registered by one cycle. sc32_fifo_data_in = dc32_fifo_data_out, combinational.
- FSM states:
  - WAIT_FRAME: wait for dc32_fifo_full=1, then go to FILL. Line count=0.
  - FILL: dc32_fifo_read_enable=1 each cycle that dc32_fifo_almost_empty=0 and issued-reads < WORDS_PER_LINE. When almost_empty=1, pause the read without losing count. After the last write lands in sc32 (last read + 1 cycle), go to READY.
  - READY: line_of_data_available=1. sc32_fifo_read_enable = get_next_word AND line_of_data_available (combinational). Count reads. The cycle the WORDS_PER_LINE-th read is issued, line_of_data_available drops on the next edge and line count increments. If line count reaches LINES_PER_FRAME go to FRAME_END, else go to FILL.
  - FRAME_END: takes 2 cycles.
    - Cycle 1: update=1, reset_per_frame=1, invert toggles on this edge.
    - Cycle 2: buffer_switch_done=1.
    - Then go to WAIT_FRAME.
- get_next_word outside READY is ignored: no sc32 read, no count change.
- dc32 is never read in READY/FRAME_END/WAIT_FRAME. A line is never prefetched while the previous line is being drained.
- reset mid-line or mid-frame: immediate return to reset values. Partial line discarded (downstream flushes on reset_all).
- Counters wide enough for parameters; no wrap within a frame.

Decomposition:
- Shared package slm_pkg: FSM state enum (WAIT_FRAME, FILL, READY, FRAME_END), default WORDS_PER_LINE/LINES_PER_FRAME constants, 32-bit word typedef.
- One natural sub-module: slm_reset_stretcher (reset -> reset_all, RESET_HOLD counter).
- Rest is a single FSM plus word and line counters.

Test Plan:
- Reset release, RESET_HOLD=4 -> reset_all high 4 cycles after reset falls. All other outputs 0. invert=0.
- WORDS_PER_LINE=4, dc32 full, almost_empty=0 -> read_enable high 4 consecutive cycles. sc32 write_enable same 4 cycles delayed by 1, data_in equals dc32 data. line_of_data_available rises the cycle after the last write.
- almost_empty raised for 3 cycles mid-fill -> read_enable low those cycles. Total reads still exactly 4. No extra writes.
- In READY, get_next_word pulsed 4 times with gaps -> sc32_fifo_read_enable only on those cycles. line_of_data_available drops after the 4th read. get_next_word during FILL produces no read.
- LINES_PER_FRAME=2, full frame -> update and reset_per_frame pulse one cycle together, buffer_switch_done pulses the next cycle, invert 0->1. A second frame returns invert to 0.
- reset asserted in READY with 2 words read -> all outputs return to reset values next edge. The following frame needs a fresh dc32_fifo_full.
